// File: rtl/red_send_pkg.sv
// Shared IR pulse-distance protocol definitions: default timing (1 cycle = 1 us),
// receiver tolerance and the transmitter/receiver state encoding.
package red_send_pkg;

   localparam int DEF_BOOT      = 13350;
   localparam int DEF_WIDTH0    = 1115;
   localparam int DEF_WIDTH1    = 2230;
   localparam int DEF_BOOT_MARK = 9000;
   localparam int DEF_MARK      = 560;
   localparam int DEF_GAP       = 1000;
   localparam int TOLERANCE     = 50;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      BIT  = 2'd2,
      STOP = 2'd3
   } state_t;

endpackage

// File: rtl/red_send_timer.sv
// Interval timer: counts 0..len-1 after each load, reports the next-cycle mark level and end of interval.
// Loads take effect on the same edge; no backpressure.
module red_send_timer (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_stop,
   input  logic [15:0] i_len,
   input  logic [15:0] i_mark_len,
   output logic        o_end,
   output logic        o_mark_nxt
);

   logic [15:0] r_cnt;
   logic [15:0] r_len;
   logic [15:0] r_mark_len;
   logic        r_run;
   logic [16:0] w_cnt_inc;

   assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
   assign o_end     = r_run && (r_cnt == r_len - 16'd1);

   // Mark level for the cycle after this edge, so the caller can register the line directly.
   always_comb begin
      o_mark_nxt = 1'b0;
      if (i_load) begin
         o_mark_nxt = (i_mark_len != 16'd0);
      end else if (r_run && !i_stop) begin
         o_mark_nxt = (w_cnt_inc < {1'b0, r_mark_len});
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt      <= 16'd0;
         r_len      <= 16'd0;
         r_mark_len <= 16'd0;
         r_run      <= 1'b0;
      end else if (i_load) begin
         r_cnt      <= 16'd0;
         r_len      <= i_len;
         r_mark_len <= i_mark_len;
         r_run      <= 1'b1;
      end else if (i_stop) begin
         r_cnt      <= 16'd0;
         r_run      <= 1'b0;
      end else if (r_run) begin
         r_cnt      <= w_cnt_inc[15:0];
      end
   end

endmodule

// File: rtl/red_send.sv
// IR pulse-distance transmitter: leader, 32 data intervals MSB first, stop mark, gap, then o_done.
// First mark starts one cycle after accept; i_start while busy is dropped, not queued.
module red_send
   import red_send_pkg::*;
#(
   parameter logic NEG       = 1'b1,
   parameter int   BOOT      = DEF_BOOT,
   parameter int   WIDTH0    = DEF_WIDTH0,
   parameter int   WIDTH1    = DEF_WIDTH1,
   parameter int   BOOT_MARK = DEF_BOOT_MARK,
   parameter int   MARK      = DEF_MARK,
   parameter int   GAP       = DEF_GAP
) (
   input  logic        i_clk_1us,
   input  logic        i_rst_n,
   input  logic [31:0] i_data,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_red
);

   localparam logic [15:0] L_BOOT  = 16'(BOOT);
   localparam logic [15:0] L_W0    = 16'(WIDTH0);
   localparam logic [15:0] L_W1    = 16'(WIDTH1);
   localparam logic [15:0] L_BMARK = 16'(BOOT_MARK);
   localparam logic [15:0] L_MARK  = 16'(MARK);
   localparam logic [15:0] L_STOP  = 16'(MARK + GAP);

   state_t      r_state;
   logic [31:0] r_shift;
   logic [4:0]  r_idx;
   logic        r_busy;
   logic        r_done;
   logic        r_red;

   logic        w_accept;
   logic        w_end;
   logic        w_load;
   logic        w_stop;
   logic        w_mark_nxt;
   logic [15:0] w_len;
   logic [15:0] w_mark_len;

   assign w_accept = i_start && !r_busy;

   // Next interval is chosen at the end of the current one; inside BIT the
   // register has not shifted yet, so the upcoming bit sits at position 30.
   always_comb begin
      w_load     = 1'b0;
      w_stop     = 1'b0;
      w_len      = L_BOOT;
      w_mark_len = L_MARK;
      case (r_state)
         IDLE: if (w_accept) begin
            w_load     = 1'b1;
            w_len      = L_BOOT;
            w_mark_len = L_BMARK;
         end
         LEAD: if (w_end) begin
            w_load = 1'b1;
            w_len  = r_shift[31] ? L_W1 : L_W0;
         end
         BIT: if (w_end) begin
            w_load = 1'b1;
            if (r_idx == 5'd31) w_len = L_STOP;
            else                w_len = r_shift[30] ? L_W1 : L_W0;
         end
         STOP: if (w_end) begin
            w_stop = 1'b1;
         end
         default: ;
      endcase
   end

   red_send_timer u_timer (
      .i_clk      (i_clk_1us),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_stop     (w_stop),
      .i_len      (w_len),
      .i_mark_len (w_mark_len),
      .o_end      (w_end),
      .o_mark_nxt (w_mark_nxt)
   );

   always_ff @(posedge i_clk_1us) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_shift <= 32'd0;
         r_idx   <= 5'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_red   <= NEG;
      end else begin
         r_done <= 1'b0;
         r_red  <= NEG ^ w_mark_nxt;
         case (r_state)
            IDLE: if (w_accept) begin
               r_shift <= i_data;
               r_idx   <= 5'd0;
               r_busy  <= 1'b1;
               r_state <= LEAD;
            end
            LEAD: if (w_end) begin
               r_state <= BIT;
            end
            BIT: if (w_end) begin
               r_shift <= {r_shift[30:0], 1'b0};
               r_idx   <= r_idx + 5'd1;
               if (r_idx == 5'd31) r_state <= STOP;
            end
            STOP: if (w_end) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_red  = r_red;

endmodule

// File: doc/red_send.md
Name: red_send

Overview:
- Transmitter for the codebase's IR pulse-distance protocol (NEC-style): serialises a 32-bit word onto a single IR line.
- Timing is defined by the interval between successive mark-start edges: one leader interval, then 32 data intervals, MSB first.
- Clocked at 1 MHz, so 1 cycle = 1 us. The output drives the IR LED modulator, or loops back to the IR receive path for self-test.

Parameters:
- NEG, 1'b1, line polarity: 1 = active-low mark (idle high, mark start is a falling edge); 0 = active-high.
- BOOT, 13350, cycles from leader mark start to first data mark start.
- WIDTH0, 1115, mark-start to next mark-start interval for a 0 bit.
- WIDTH1, 2230, mark-start to next mark-start interval for a 1 bit.
- BOOT_MARK, 9000, leader mark duration (cycles); must be < BOOT.
- MARK, 560, data/stop mark duration; must be < WIDTH0.
- GAP, 1000, minimum idle cycles after the stop mark before o_done.

Ports:
- i_clk_1us  in  1  1 MHz clock, all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_data  in  32  word to send; sampled only on accept.
- i_start  in  1  request; accepted when i_start=1 and o_busy=0.
- o_busy  out  1  frame in progress (registered).
- o_done  out  1  one-cycle pulse at frame completion (registered).
- o_red  out  1  IR line (registered); idle level = NEG, mark level = ~NEG.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): o_red=NEG, o_busy=0, o_done=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts immediately; the line returns to idle on that edge; the frame is discarded.
- Accept: i_start=1 while o_busy=0 at edge t.
  - Latch i_data into the shift register.
  - At t+1: o_busy=1, o_red=~NEG. This is mark start E0.
  - i_start while busy is ignored, not queued.
- Mark-start edges, counted from T0 = t+1:
  - E1 at T0+BOOT.
  - E(2+i) at E(1+i)+(bit ? WIDTH1 : WIDTH0), for i=0..31, bit = data[31-i].
  - 34 mark-start edges in total. E33 is the stop mark, ending the final interval.
- Mark duration after each edge: BOOT_MARK after E0, MARK after all others. The line is at idle level otherwise.
- Intervals are exact, with 0 cycles error; the receiver tolerance is ±49.
- FSM:
  - IDLE -> LEAD on accept.
  - LEAD -> BIT when count reaches BOOT-1.
  - BIT stays for 32 intervals; the bit index runs 0..31. At the end of each interval it shifts the register left by 1.
  - BIT -> STOP after bit 31's interval.
  - STOP holds MARK cycles of mark, then GAP cycles of idle, then -> IDLE.
  - On the STOP -> IDLE transition: o_done=1 and o_busy=0 in the same cycle.
  - Earliest next accept is at that same edge: o_busy reads 0 there, so a new frame's E0 can follow on the next cycle.
- Interval counter: 16 bits, cleared at every mark start, counts 0..len-1.
  - Mark level holds while count < mark_len.
  - Reaching len-1 ends the interval.
- Interval length is selected from the current MSB of the shift register.
- Frame length: BOOT + sum(intervals) + MARK + GAP + 1 cycles from accept to o_done.
  - All zeros: 13350+32*1115+560+1000+1 = 50591.
  - All ones: 86271.
- The 16-bit counter must hold BOOT and BOOT_MARK; the parameter maximum is 65535.

Decomposition:
- Shared header, included by this block and the receiver:
  - default timing constants BOOT, WIDTH0, WIDTH1, MARK, BOOT_MARK;
  - tolerance value 50;
  - state encodings IDLE/LEAD/BIT/STOP.
- One natural sub-module, red_send_timer:
  - loads (len, mark_len) and counts;
  - outputs the mark level and an end-of-interval pulse.
- The top level holds the FSM, shift register and bit index.

Test Plan:
- Reset then idle 100 cycles -> o_red=1, o_busy=0, o_done=0 throughout.
- i_data=32'h00000000, start -> falling edges at T0, T0+13350, then every 1115; exactly 34 falling edges; first low phase 9000 cycles, others 560; o_done at accept+50591.
- i_data=32'hFFFFFFFF -> data intervals all 2230; o_done at accept+86271.
- i_data=32'h00FFA55A looped into the codebase IR receiver (default params, NEG=1) -> receiver data = 32'h00FFA55A with one interrupt pulse; interval sequence matches bits MSB first.
- i_start re-pulsed mid-frame at bit 10 with different data -> ignored, waveform unchanged. i_start held high through o_done -> next frame E0 one cycle after the o_done cycle.
- i_rst_n=0 during bit 5 mark -> o_red=1 and o_busy=0 at that edge; no o_done; next start yields a clean full frame.
